// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   UART 8N1 receive front end. The serial line is synchronised and then
//   oversampled. Each good character appears on out_data together with a
//   one-cycle data_valid strobe. 8'hFF is passed through like any other byte.
//
// Ports
//   count_clock  in   1  sole clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   rx           in   1  raw serial line, idle high, asynchronous
//   out_data     out  8  last good byte, held until the next good byte
//   data_valid   out  1  one-cycle pulse, out_data updated this cycle
//   frame_err    out  1  one-cycle pulse, stop bit sampled low
//   busy         out  1  receiver not in IDLE
//
// State table
//   IDLE  | waiting for a low level on the synchronised line
//   START | checking the start bit at mid-bit, rejecting glitches
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling the stop bit at mid-bit
//   BREAK | stop bit was low; waiting for the line to return high

module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       count_clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ccnt, ccnt_nxt;
  logic [2:0]    bcnt, bcnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          ferr_nxt;

  logic sync1, sync2;
  logic rxs;

  // Two-flop synchroniser. The flops reset to the idle level, so no false
  // start bit is seen when reset is released.
  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rxs = sync2;

  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ccnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      out_data   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ccnt       <= ccnt_nxt;
      bcnt       <= bcnt_nxt;
      shreg      <= shreg_nxt;
      out_data   <= data_nxt;
      data_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ccnt_nxt  = ccnt + CNT_ONE;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    data_nxt  = out_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        ccnt_nxt = '0;
        if (!rxs) state_nxt = START;
      end

      START: begin
        if (ccnt == HALF_LAST) begin
          ccnt_nxt = '0;
          if (!rxs) begin
            state_nxt = DATA;
            bcnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        if (ccnt == BIT_LAST) begin
          ccnt_nxt  = '0;
          shreg_nxt = {rxs, shreg[7:1]};
          if (bcnt == 3'd7) state_nxt = STOP;
          else              bcnt_nxt  = bcnt + 3'd1;
        end
      end

      STOP: begin
        // Leaving at mid stop bit leaves half a bit of margin, so a start
        // bit that follows with zero idle gap is still detected.
        if (ccnt == BIT_LAST) begin
          ccnt_nxt = '0;
          if (rxs) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end

      BREAK: begin
        ccnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end

      default: begin
        ccnt_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
